// File: rtl/xm_pipe_latch.sv
// Execute/memory pipeline register.
// Latches NUM_FIELDS words plus a valid bit between the execute and
// data-memory stages. The hazard unit can hold the latch (stall) or
// replace its contents with a bubble (flush).
// Two saturating counters record stalled cycles and bubbles entering the
// latch, so hazard behaviour can be observed while debugging.
//
// Datapath priority at each rising edge: reset > flush > stall > load.
// Counter priority at each rising edge: reset > cnt_clr > increment.
// Every output comes straight from a flop; no input reaches an output
// combinationally.
module xm_pipe_latch #(
   parameter int WIDTH      = 32,
   parameter int NUM_FIELDS = 3,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        stall,
   input  logic                        flush,
   input  logic                        in_valid,
   input  logic [NUM_FIELDS*WIDTH-1:0] data_in,
   input  logic                        cnt_clr,
   output logic                        out_valid,
   output logic [NUM_FIELDS*WIDTH-1:0] data_out,
   output logic [CNT_WIDTH-1:0]        stall_cnt,
   output logic [CNT_WIDTH-1:0]        bubble_cnt
);

   localparam int DW = NUM_FIELDS * WIDTH;
   localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
   localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

   logic [DW-1:0]        data_q, data_d;
   logic                 valid_q, valid_d;
   logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;
   logic [CNT_WIDTH-1:0] bubble_cnt_q, bubble_cnt_d;

   // Event qualifiers.
   // A flush wins over a stall, so a stalled-and-flushed edge counts only
   // as a bubble.
   // A stalled edge never counts as a bubble, even when in_valid is low.
   logic stall_evt;
   logic bubble_evt;
   assign stall_evt  = stall & ~flush;
   assign bubble_evt = flush | (~stall & ~in_valid);

   // Next-state datapath: the flush bubble is all zeros, which is the NOP
   // encoding of the IR.
   // Fields are captured even when in_valid is low.
   always_comb begin
      data_d  = data_q;
      valid_d = valid_q;
      if (flush) begin
         data_d  = '0;
         valid_d = 1'b0;
      end else if (!stall) begin
         data_d  = data_in;
         valid_d = in_valid;
      end
   end

   // Next-state counters: clear beats increment; increments stop at all-ones.
   always_comb begin
      stall_cnt_d  = stall_cnt_q;
      bubble_cnt_d = bubble_cnt_q;
      if (cnt_clr) begin
         stall_cnt_d  = '0;
         bubble_cnt_d = '0;
      end else begin
         if (stall_evt && (stall_cnt_q != CNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + CNT_ONE;
         end
         if (bubble_evt && (bubble_cnt_q != CNT_MAX)) begin
            bubble_cnt_d = bubble_cnt_q + CNT_ONE;
         end
      end
   end

   // Latch register: reset discards any held or flushed contents.
   always_ff @(posedge clk) begin
      if (reset) begin
         data_q  <= '0;
         valid_q <= 1'b0;
      end else begin
         data_q  <= data_d;
         valid_q <= valid_d;
      end
   end

   // Performance counter registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         stall_cnt_q  <= '0;
         bubble_cnt_q <= '0;
      end else begin
         stall_cnt_q  <= stall_cnt_d;
         bubble_cnt_q <= bubble_cnt_d;
      end
   end

   assign data_out   = data_q;
   assign out_valid  = valid_q;
   assign stall_cnt  = stall_cnt_q;
   assign bubble_cnt = bubble_cnt_q;

endmodule

// File: tb/tb_xm_pipe_latch.sv
// Bench for xm_pipe_latch.
// Instance A uses the default parameters. It runs a vector table followed
// by a random phase checked against a reference model.
// Instance B uses WIDTH=8, NUM_FIELDS=2 and CNT_WIDTH=4. It runs
// hand-written sequences for counter saturation, counter clear and reset
// during a stall.
module tb_xm_pipe_latch;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   always #5 clk = ~clk;

   // Instance A (defaults).
   logic        reset_a, stall_a, flush_a, in_valid_a, cnt_clr_a;
   logic [95:0] data_in_a, data_out_a;
   logic        out_valid_a;
   logic [15:0] stall_cnt_a, bubble_cnt_a;

   // Instance B (WIDTH=8, NUM_FIELDS=2, CNT_WIDTH=4).
   logic        reset_b, stall_b, flush_b, in_valid_b, cnt_clr_b;
   logic [15:0] data_in_b, data_out_b;
   logic        out_valid_b;
   logic [3:0]  stall_cnt_b, bubble_cnt_b;

   xm_pipe_latch u_dut_a (
      .clk(clk), .reset(reset_a), .stall(stall_a), .flush(flush_a),
      .in_valid(in_valid_a), .data_in(data_in_a), .cnt_clr(cnt_clr_a),
      .out_valid(out_valid_a), .data_out(data_out_a),
      .stall_cnt(stall_cnt_a), .bubble_cnt(bubble_cnt_a)
   );

   xm_pipe_latch #(.WIDTH(8), .NUM_FIELDS(2), .CNT_WIDTH(4)) u_dut_b (
      .clk(clk), .reset(reset_b), .stall(stall_b), .flush(flush_b),
      .in_valid(in_valid_b), .data_in(data_in_b), .cnt_clr(cnt_clr_b),
      .out_valid(out_valid_b), .data_out(data_out_b),
      .stall_cnt(stall_cnt_b), .bubble_cnt(bubble_cnt_b)
   );

   // ---------------- scoreboard ----------------
   typedef struct {
      logic [95:0] data;
      logic        valid;
      logic [15:0] sc;
      logic [15:0] bc;
   } exp_t;

   typedef struct {
      logic        rst, stl, fl, iv, clr;
      logic [95:0] din;
      exp_t        e;
   } vec_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   function automatic exp_t mk_exp(input logic [95:0] d, input logic v,
                                   input logic [15:0] sc, input logic [15:0] bc);
      exp_t e;
      e.data = d; e.valid = v; e.sc = sc; e.bc = bc;
      return e;
   endfunction

   function automatic vec_t mk_vec(input logic rst, input logic stl, input logic fl,
                                   input logic iv, input logic clr, input logic [95:0] din,
                                   input exp_t e);
      vec_t v;
      v.rst = rst; v.stl = stl; v.fl = fl; v.iv = iv; v.clr = clr; v.din = din; v.e = e;
      return v;
   endfunction

   task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Pops one expectation and compares it with the sampled outputs.
   task automatic compare(input string tag, input logic [95:0] d, input logic v,
                          input logic [15:0] sc, input logic [15:0] bc);
      exp_t e;
      if (exp_q.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL %s: scoreboard empty", tag);
      end else begin
         e = exp_q.pop_front();
         chk({tag, " data_out"},   d,           e.data);
         chk({tag, " out_valid"},  {95'b0, v},  {95'b0, e.valid});
         chk({tag, " stall_cnt"},  {80'b0, sc}, {80'b0, e.sc});
         chk({tag, " bubble_cnt"}, {80'b0, bc}, {80'b0, e.bc});
      end
   endtask

   // ---------------- driver tasks ----------------
   // Inputs change on the falling edge; outputs are sampled 1 ns after the
   // rising edge.
   task automatic apply_a(input string tag, input vec_t v);
      @(negedge clk);
      reset_a = v.rst; stall_a = v.stl; flush_a = v.fl;
      in_valid_a = v.iv; cnt_clr_a = v.clr; data_in_a = v.din;
      exp_q.push_back(v.e);
      @(posedge clk);
      #1;
      compare(tag, data_out_a, out_valid_a, stall_cnt_a, bubble_cnt_a);
   endtask

   task automatic apply_b(input string tag, input logic rst, input logic stl, input logic fl,
                          input logic iv, input logic clr, input logic [15:0] din,
                          input exp_t e);
      @(negedge clk);
      reset_b = rst; stall_b = stl; flush_b = fl;
      in_valid_b = iv; cnt_clr_b = clr; data_in_b = din;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      compare(tag, {80'b0, data_out_b}, out_valid_b, {12'b0, stall_cnt_b}, {12'b0, bubble_cnt_b});
   endtask

   // ---------------- test ----------------
   localparam logic [95:0] LOAD = {32'h8C220004, 32'h00000005, 32'h00001000};
   localparam logic [95:0] ONES = {96{1'b1}};
   localparam logic [95:0] PAT  = {3{32'h12345678}};
   localparam logic [95:0] XV   = {32'hDEADBEEF, 32'h00000000, 32'hCAFEF00D};
   localparam logic [95:0] Z    = 96'h0;

   vec_t vecs[16];

   // Reference model state for the random phase.
   logic [95:0] m_data;
   logic        m_valid;
   logic [15:0] m_sc, m_bc;

   initial begin
      reset_a = 1'b1; stall_a = 1'b0; flush_a = 1'b0; in_valid_a = 1'b0;
      cnt_clr_a = 1'b0; data_in_a = '0;
      reset_b = 1'b1; stall_b = 1'b0; flush_b = 1'b0; in_valid_b = 1'b0;
      cnt_clr_b = 1'b0; data_in_b = '0;

      // Each entry is {reset, stall, flush, in_valid, cnt_clr, data_in}
      // followed by the expected outputs after that rising edge.
      vecs[0]  = mk_vec(1, 0, 0, 0, 0, Z,    mk_exp(Z,    0, 16'd0, 16'd0));
      vecs[1]  = mk_vec(1, 0, 0, 1, 0, LOAD, mk_exp(Z,    0, 16'd0, 16'd0));
      vecs[2]  = mk_vec(0, 0, 0, 1, 0, LOAD, mk_exp(LOAD, 1, 16'd0, 16'd0));
      vecs[3]  = mk_vec(0, 1, 0, 1, 0, ONES, mk_exp(LOAD, 1, 16'd1, 16'd0));
      vecs[4]  = mk_vec(0, 1, 0, 1, 0, ONES, mk_exp(LOAD, 1, 16'd2, 16'd0));
      vecs[5]  = mk_vec(0, 1, 0, 1, 0, ONES, mk_exp(LOAD, 1, 16'd3, 16'd0));
      vecs[6]  = mk_vec(0, 0, 0, 1, 0, ONES, mk_exp(ONES, 1, 16'd3, 16'd0));
      vecs[7]  = mk_vec(0, 1, 1, 1, 0, ONES, mk_exp(Z,    0, 16'd3, 16'd1));
      vecs[8]  = mk_vec(0, 0, 0, 0, 0, PAT,  mk_exp(PAT,  0, 16'd3, 16'd2));
      vecs[9]  = mk_vec(0, 0, 0, 1, 1, XV,   mk_exp(XV,   1, 16'd0, 16'd0));
      vecs[10] = mk_vec(0, 0, 1, 1, 1, XV,   mk_exp(Z,    0, 16'd0, 16'd0));
      vecs[11] = mk_vec(0, 1, 1, 1, 0, PAT,  mk_exp(Z,    0, 16'd0, 16'd1));
      vecs[12] = mk_vec(0, 1, 0, 0, 0, ONES, mk_exp(Z,    0, 16'd1, 16'd1));
      vecs[13] = mk_vec(1, 1, 0, 1, 0, ONES, mk_exp(Z,    0, 16'd0, 16'd0));
      vecs[14] = mk_vec(1, 0, 1, 1, 1, XV,   mk_exp(Z,    0, 16'd0, 16'd0));
      vecs[15] = mk_vec(0, 0, 0, 1, 0, XV,   mk_exp(XV,   1, 16'd0, 16'd0));

      for (int i = 0; i < 16; i++) begin
         apply_a($sformatf("a_vec[%0d]", i), vecs[i]);
      end

      // Random phase on instance A, checked against a reference model.
      m_data = XV; m_valid = 1'b1; m_sc = 16'd0; m_bc = 16'd0;
      for (int i = 0; i < 60; i++) begin
         vec_t v;
         v.rst = ($urandom_range(15, 0) == 0);
         v.stl = ($urandom_range(3, 0) == 0);
         v.fl  = ($urandom_range(7, 0) == 0);
         v.iv  = ($urandom_range(3, 0) != 0);
         v.clr = ($urandom_range(15, 0) == 0);
         v.din = {$urandom, $urandom, $urandom};
         if (v.rst) begin
            m_data = '0; m_valid = 1'b0; m_sc = 16'd0; m_bc = 16'd0;
         end else begin
            if (v.clr) begin
               m_sc = 16'd0;
               m_bc = 16'd0;
            end else begin
               if (v.stl && !v.fl && m_sc != 16'hFFFF) m_sc = m_sc + 16'd1;
               if ((v.fl || (!v.stl && !v.iv)) && m_bc != 16'hFFFF) m_bc = m_bc + 16'd1;
            end
            if (v.fl) begin
               m_data = '0; m_valid = 1'b0;
            end else if (!v.stl) begin
               m_data = v.din; m_valid = v.iv;
            end
         end
         v.e = mk_exp(m_data, m_valid, m_sc, m_bc);
         apply_a($sformatf("a_rand[%0d]", i), v);
      end

      // Instance B: reset, then load fields 1/0 = 0xA5/0x3C.
      apply_b("b_rst0", 1, 0, 0, 0, 0, 16'h0, mk_exp(Z, 0, 16'd0, 16'd0));
      apply_b("b_rst1", 1, 0, 0, 0, 0, 16'h0, mk_exp(Z, 0, 16'd0, 16'd0));
      apply_b("b_load", 0, 0, 0, 1, 0, 16'hA53C, mk_exp(96'hA53C, 1, 16'd0, 16'd0));

      // Stall counter saturates at 15.
      for (int i = 0; i < 20; i++) begin
         apply_b($sformatf("b_stall[%0d]", i), 0, 1, 0, 1, 0, 16'hFFFF,
                 mk_exp(96'hA53C, 1, (i + 1 > 15) ? 16'd15 : 16'(i + 1), 16'd0));
      end

      // Clear during a stall: the counters clear and the data is held.
      apply_b("b_clr_stall", 0, 1, 0, 1, 1, 16'hFFFF, mk_exp(96'hA53C, 1, 16'd0, 16'd0));
      apply_b("b_stall_post", 0, 1, 0, 1, 0, 16'hFFFF, mk_exp(96'hA53C, 1, 16'd1, 16'd0));

      // Reset during a stall discards the held contents.
      apply_b("b_rst_stall", 1, 1, 0, 1, 0, 16'hFFFF, mk_exp(Z, 0, 16'd0, 16'd0));
      apply_b("b_resume", 0, 0, 0, 1, 0, 16'h1234, mk_exp(96'h1234, 1, 16'd0, 16'd0));

      // Bubble counter saturates at 15 under repeated flushes.
      for (int i = 0; i < 20; i++) begin
         apply_b($sformatf("b_flush[%0d]", i), 0, 0, 1, 1, 0, 16'hBEEF,
                 mk_exp(Z, 0, 16'd0, (i + 1 > 15) ? 16'd15 : 16'(i + 1)));
      end

      // A clear beats a simultaneous bubble increment.
      apply_b("b_clr_flush", 0, 0, 1, 1, 1, 16'hBEEF, mk_exp(Z, 0, 16'd0, 16'd0));
      apply_b("b_bubble_iv0", 0, 0, 0, 0, 0, 16'h00FF, mk_exp(96'h00FF, 0, 16'd0, 16'd1));

      if (exp_q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL scoreboard_drain: %0d left, expected 0", exp_q.size());
      end

      // ---------------- final report ----------------
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
